l2_ic_responder: RTL and testbench

Responder end of the I-cache miss interface: accepts line-fill requests raised by the I-cache controller on `irq`/`l2_addr` and returns a 128-bit line on `data_wd_l2` with a one-cycle `l2_rdy` pulse. It holds a one-entry line buffer. A buffer hit answers in one cycle. A miss fetches the line as four 32-bit beats over a req/ack main-memory port. It sits between the IF stage cache controller and the memory bus.

---
 rtl/l2_ic_responder_pkg.sv | 21 ++
 rtl/l2_ic_responder_if.sv | 31 +++
 rtl/l2_ic_line_buf.sv | 41 ++++
 rtl/l2_ic_responder.sv | 110 +++++++++++
 tb/tb_l2_ic_responder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_ic_responder_pkg.sv
// Shared widths and FSM state encodings for the I-cache miss responder.
package l2_ic_responder_pkg;

    localparam int L2_LINE_W  = 128;
    localparam int L2_ADDR_W  = 28;
    localparam int MEM_ADDR_W = 30;
    localparam int WORD_W     = 32;

    typedef logic [L2_LINE_W-1:0]  l2_line_t;   // L2_LINE_BUS  127:0
    typedef logic [L2_ADDR_W-1:0]  l2_addr_t;   // L2_ADDR_BUS  27:0
    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;  // MEM_ADDR_BUS 29:0
    typedef logic [WORD_W-1:0]     word_t;

    typedef enum logic [1:0] {
        L2R_IDLE  = 2'd0,
        L2R_FETCH = 2'd1,
        L2R_RESP  = 2'd2,
        L2R_DONE  = 2'd3
    } l2r_state_t;

endpackage

// File: rtl/l2_ic_responder_if.sv
// I-cache miss request/response signals plus the beat-wise main-memory port.
// Handshakes: a request is the level irq & ic_rw_en & ~l2_cache_rw, held until the one-cycle l2_rdy
// pulse; a memory beat transfers on the cycle where mem_req & mem_ack, with mem_req/mem_addr held until then.
interface l2_ic_responder_if;
    import l2_ic_responder_pkg::*;

    logic      irq;
    logic      ic_rw_en;
    l2_addr_t  l2_addr;
    logic      l2_cache_rw;
    logic      inv;
    logic      ic_en;
    logic      l2_rdy;
    l2_line_t  data_wd_l2;
    logic      mem_wr_ic_en;
    logic      mem_req;
    mem_addr_t mem_addr;
    logic      mem_ack;
    word_t     mem_rdata;

    modport slave (
        input  irq, ic_rw_en, l2_addr, l2_cache_rw, inv, mem_ack, mem_rdata,
        output ic_en, l2_rdy, data_wd_l2, mem_wr_ic_en, mem_req, mem_addr
    );

    modport master (
        output irq, ic_rw_en, l2_addr, l2_cache_rw, inv, mem_ack, mem_rdata,
        input  ic_en, l2_rdy, data_wd_l2, mem_wr_ic_en, mem_req, mem_addr
    );

endinterface

// File: rtl/l2_ic_line_buf.sv
// One-entry line buffer: tag/valid/data with hit compare, load port and invalidate.
module l2_ic_line_buf
    import l2_ic_responder_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     inv,
    input  l2_addr_t lookup_tag,
    output logic     hit,
    output l2_line_t rd_data,
    input  logic     load,
    input  l2_addr_t load_tag,
    input  l2_line_t load_data
);

    logic     valid;
    l2_addr_t tag;
    l2_line_t data;

    // inv wins over a simultaneous load so a line invalidated during its own fill stays invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (load) begin
                tag  <= load_tag;
                data <= load_data;
            end
            if (inv)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
        end
    end

    assign hit     = valid & ~inv & (tag == lookup_tag);
    assign rd_data = data;

endmodule

// File: rtl/l2_ic_responder.sv
// Responder FSM: answers line fills from the line buffer or assembles four memory beats.
module l2_ic_responder
    import l2_ic_responder_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    l2_ic_responder_if.slave bus,
    output l2r_state_t    dbg_state
);

    l2r_state_t state, state_next;
    logic [1:0] beat;
    l2_addr_t   req_addr;
    l2_line_t   line_asm, line_next, data_q, buf_data;
    logic       from_mem_q, inv_pend;
    logic       accept, hit, beat_ack, last_ack, buf_load;
    logic       ic_en, l2_rdy, mem_req;

    assign accept   = (state == L2R_IDLE) & bus.irq & bus.ic_rw_en & ~bus.l2_cache_rw;
    assign beat_ack = (state == L2R_FETCH) & bus.mem_ack;
    assign last_ack = beat_ack & (beat == 2'd3);
    assign buf_load = last_ack & ~inv_pend;

    l2_ic_line_buf u_line_buf (
        .clk        (clk),
        .reset      (reset),
        .inv        (bus.inv),
        .lookup_tag (bus.l2_addr),
        .hit        (hit),
        .rd_data    (buf_data),
        .load       (buf_load),
        .load_tag   (req_addr),
        .load_data  (line_next)
    );

    always_comb begin
        line_next = line_asm;
        line_next[{beat, 5'd0} +: WORD_W] = bus.mem_rdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= L2R_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ic_en      = 1'b0;
        l2_rdy     = 1'b0;
        mem_req    = 1'b0;
        case (state)
            L2R_IDLE:  if (accept) state_next = hit ? L2R_RESP : L2R_FETCH;
            L2R_FETCH: begin
                ic_en   = 1'b1;
                mem_req = 1'b1;
                if (last_ack) state_next = L2R_RESP;
            end
            L2R_RESP: begin
                ic_en      = 1'b1;
                l2_rdy     = 1'b1;
                state_next = L2R_DONE;
            end
            L2R_DONE:  state_next = L2R_IDLE;
            default:   state_next = L2R_IDLE;
        endcase
    end

    // An inv seen at any point of a fill keeps the fetched line out of the buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat       <= 2'd0;
            req_addr   <= '0;
            line_asm   <= '0;
            data_q     <= '0;
            from_mem_q <= 1'b0;
            inv_pend   <= 1'b0;
        end else begin
            if (accept) begin
                req_addr <= bus.l2_addr;
                beat     <= 2'd0;
                inv_pend <= 1'b0;
                if (hit) begin
                    data_q     <= buf_data;
                    from_mem_q <= 1'b0;
                end
            end
            if ((state == L2R_FETCH) && bus.inv)
                inv_pend <= 1'b1;
            if (beat_ack) begin
                line_asm <= line_next;
                beat     <= beat + 2'd1;
            end
            if (last_ack) begin
                data_q     <= line_next;
                from_mem_q <= 1'b1;
            end
        end
    end

    assign bus.ic_en        = ic_en;
    assign bus.l2_rdy       = l2_rdy;
    assign bus.mem_req      = mem_req;
    assign bus.mem_addr     = {req_addr, beat};
    assign bus.data_wd_l2   = data_q;
    assign bus.mem_wr_ic_en = from_mem_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_l2_ic_responder.sv
// Randomized bench for l2_ic_responder with a line-level reference model and scoreboard.
module tb_l2_ic_responder;
    import l2_ic_responder_pkg::*;

    logic       clk;
    logic       reset;
    l2r_state_t dbg_state;

    l2_ic_responder_if bus();

    l2_ic_responder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    logic [128:0] exp_q[$];
    int unsigned  exp_cyc_q[$];
    mem_addr_t    exp_addr_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int unsigned  cyc = 0;
    int           cur_wait = 0;
    bit           m_valid = 0;
    l2_addr_t     m_tag = '0;
    l2_addr_t     pool[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: the test-plan line at 0x10 plus an address hash elsewhere
    function automatic word_t mem_word(input mem_addr_t a);
        if (a[29:2] == 28'h0000010)
            return 32'h11111111 * {30'd0, a[1:0]} + 32'h11111111;
        return {a[15:0], a[29:14]} ^ 32'h5A3C96E1;
    endfunction

    function automatic l2_line_t model_line(input l2_addr_t a);
        return {mem_word({a, 2'd3}), mem_word({a, 2'd2}), mem_word({a, 2'd1}), mem_word({a, 2'd0})};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every l2_rdy pulse pops one expected line
    initial begin
        logic [128:0] e;
        int unsigned  c;
        forever begin
            @(negedge clk);
            if (reset && bus.l2_rdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_l2_rdy: actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("line", bus.data_wd_l2, e[127:0]);
                    check("mem_wr_ic_en", {127'd0, bus.mem_wr_ic_en}, {127'd0, e[128]});
                    check("rdy_cycle", 128'(cyc), 128'(c));
                end
            end
        end
    end

    // Memory model: cur_wait idle cycles before each ack, address checked every request cycle
    initial begin
        bit started;
        int wcnt;
        started = 0;
        wcnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset && bus.mem_req) begin
                if (!started) begin
                    started = 1;
                    wcnt = cur_wait;
                end
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_mem_req: actual addr=%0h required no request", bus.mem_addr);
                end else begin
                    check("mem_addr", 128'(bus.mem_addr), 128'(exp_addr_q[0]));
                end
                if (wcnt == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    started = 0;
                    if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                end else begin
                    bus.mem_ack = 1'b0;
                    bus.mem_rdata = $urandom;
                    wcnt--;
                end
            end else begin
                bus.mem_ack = 1'b0;
                started = 0;
            end
        end
    end

    // inv_mode: 0 none, 1 with the request, 2 at fetch cycle inv_k, 3 standalone before the request
    task automatic do_req(input l2_addr_t a, input int w, input int inv_mode, input int inv_k, input bit hold);
        bit hit;
        bit got;
        int lat;
        int cnt;
        int mode;
        mode = inv_mode;
        @(negedge clk);
        if (mode == 3) begin
            bus.inv = 1'b1;
            m_valid = 0;
            @(negedge clk);
            bus.inv = 1'b0;
        end
        hit = m_valid && (m_tag == a) && (mode != 1);
        if (hit && mode == 2) mode = 0;
        lat = hit ? 0 : 4 * (w + 1);
        exp_q.push_back({~hit, model_line(a)});
        exp_cyc_q.push_back(cyc + 1 + lat);
        if (!hit)
            for (int b = 0; b < 4; b++) exp_addr_q.push_back({a, 2'(b)});
        cur_wait = w;
        bus.irq = 1'b1;
        bus.ic_rw_en = 1'b1;
        bus.l2_cache_rw = 1'b0;
        bus.l2_addr = a;
        bus.inv = (mode == 1);
        cnt = 0;
        got = 0;
        while (!got && cnt < 200) begin
            @(negedge clk);
            cnt++;
            bus.inv = (mode == 2) && (cnt == inv_k);
            if (cnt == 1) check("ic_en_busy", {127'd0, bus.ic_en}, 128'd1);
            if (bus.l2_rdy) got = 1;
        end
        bus.inv = 1'b0;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rdy_timeout: actual=no l2_rdy in %0d cycles required=l2_rdy", cnt);
        end
        if (hold) begin
            @(negedge clk);
            bus.l2_addr = ~a;
            @(negedge clk);
            check("no_accept_in_done", {127'd0, bus.ic_en}, 128'd0);
        end
        bus.irq = 1'b0;
        bus.ic_rw_en = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("ic_en_released", {127'd0, bus.ic_en}, 128'd0);
        if (!hit) begin
            m_tag = a;
            m_valid = (mode != 2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        l2_addr_t a;
        int w;
        reset = 1'b0;
        bus.irq = 1'b0;
        bus.ic_rw_en = 1'b0;
        bus.l2_addr = '0;
        bus.l2_cache_rw = 1'b0;
        bus.inv = 1'b0;
        @(negedge clk);
        check("rst_ic_en", {127'd0, bus.ic_en}, 128'd0);
        check("rst_l2_rdy", {127'd0, bus.l2_rdy}, 128'd0);
        check("rst_mem_req", {127'd0, bus.mem_req}, 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_data", bus.data_wd_l2, 128'd0);
        check("rst_mem_wr", {127'd0, bus.mem_wr_ic_en}, 128'd0);
        check("rst_state", 128'(dbg_state), 128'(L2R_IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // cold miss, hit, wait states
        do_req(28'h0000010, 0, 0, 0, 0);
        check("cold_line_const", model_line(28'h0000010), 128'h44444444_33333333_22222222_11111111);
        do_req(28'h0000010, 0, 0, 0, 0);
        do_req(28'h0000020, 2, 0, 0, 0);
        // inv in the second fetch beat, then the same address must miss
        do_req(28'h0000030, 0, 2, 2, 0);
        do_req(28'h0000030, 0, 0, 0, 0);
        // irq held through DONE
        do_req(28'h0000030, 0, 0, 0, 1);

        // writes and unqualified requests are never accepted
        @(negedge clk);
        bus.irq = 1'b1;
        bus.l2_cache_rw = 1'b1;
        bus.ic_rw_en = 1'b1;
        bus.l2_addr = 28'h0000010;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                bus.l2_cache_rw = 1'b0;
                bus.ic_rw_en = 1'b0;
            end
            @(negedge clk);
            check("ignore_ic_en", {127'd0, bus.ic_en}, 128'd0);
            check("ignore_mem_req", {127'd0, bus.mem_req}, 128'd0);
        end
        bus.irq = 1'b0;
        bus.l2_cache_rw = 1'b0;

        // reset in the middle of a fill, after beats 0 and 1
        @(negedge clk);
        a = 28'h0ABCDE5;
        cur_wait = 0;
        for (int b = 0; b < 4; b++) exp_addr_q.push_back({a, 2'(b)});
        bus.irq = 1'b1;
        bus.ic_rw_en = 1'b1;
        bus.l2_addr = a;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_mem_req", {127'd0, bus.mem_req}, 128'd0);
        check("midrst_ic_en", {127'd0, bus.ic_en}, 128'd0);
        check("midrst_l2_rdy", {127'd0, bus.l2_rdy}, 128'd0);
        check("midrst_data", bus.data_wd_l2, 128'd0);
        check("midrst_state", 128'(dbg_state), 128'(L2R_IDLE));
        bus.irq = 1'b0;
        exp_addr_q.delete();
        m_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_req(a, 0, 0, 0, 0);
        do_req(a, 1, 0, 0, 0);

        // randomized traffic over a small address pool so hits occur
        pool[0] = 28'h0000010;
        pool[1] = 28'h0000011;
        pool[2] = 28'hABCDEF0;
        pool[3] = 28'($urandom);
        for (int i = 0; i < 40; i++) begin
            w = $urandom_range(0, 2);
            do_req(pool[$urandom_range(0, 3)], w, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                   $urandom_range(1, 4 * (w + 1)), $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", 128'(exp_q.size()), 128'd0);
        check("exp_addr_drained", 128'(exp_addr_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
